// File: rtl/unified_memory_arbiter_if.sv
// Bundle of fetch, data and external memory bus signals
// around the unified memory arbiter.
interface unified_memory_arbiter_if;
    logic        fetchRequest;
    logic [31:0] fetchAddress;
    logic        fetchFlush;
    logic        fetchReady;
    logic [31:0] fetchReadData;
    logic        dataReadEnable;
    logic        dataWriteEnable;
    logic [31:0] dataAddress;
    logic [31:0] dataWriteData;
    logic [3:0]  dataByteEnable;
    logic        dataReady;
    logic [31:0] dataReadData;
    logic        memRequest;
    logic        memWrite;
    logic [31:0] memAddress;
    logic [31:0] memWriteData;
    logic [3:0]  memByteEnable;
    logic        memAcknowledge;
    logic [31:0] memReadData;
    logic        accessFault;

    modport slave (
        input  fetchRequest, fetchAddress, fetchFlush,
        input  dataReadEnable, dataWriteEnable, dataAddress,
        input  dataWriteData, dataByteEnable,
        input  memAcknowledge, memReadData,
        output fetchReady, fetchReadData,
        output dataReady, dataReadData,
        output memRequest, memWrite, memAddress,
        output memWriteData, memByteEnable, accessFault
    );

    modport master (
        output fetchRequest, fetchAddress, fetchFlush,
        output dataReadEnable, dataWriteEnable, dataAddress,
        output dataWriteData, dataByteEnable,
        output memAcknowledge, memReadData,
        input  fetchReady, fetchReadData,
        input  dataReady, dataReadData,
        input  memRequest, memWrite, memAddress,
        input  memWriteData, memByteEnable, accessFault
    );
endinterface

// File: rtl/unified_memory_arbiter.sv
// Fetch/data arbiter for the single external memory port.
// Optional bus timeout enabled by defining ARB_TIMEOUT_EN.
module unified_memory_arbiter #(
    parameter int STARVE_LIMIT   = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input logic clock,
    input logic resetN,
    unified_memory_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE, FETCH, DATA, FETCH_DROP
    } state_e;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    state_e      state_q, state_d;
    logic [3:0]  starve_q, starve_d;
    logic        mem_req_q, mem_req_d;
    logic        mem_write_q, mem_write_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [3:0]  mem_be_q, mem_be_d;
    logic        fetch_ready_q, fetch_ready_d;
    logic [31:0] fetch_rdata_q, fetch_rdata_d;
    logic        data_ready_q, data_ready_d;
    logic [31:0] data_rdata_q, data_rdata_d;
    logic        fault_q, fault_d;
    logic        data_req, fetch_ok;
    logic        grant_fetch, grant_data;
    logic        timeout;

    assign data_req = bus.dataReadEnable | bus.dataWriteEnable;
    assign fetch_ok = bus.fetchRequest & ~bus.fetchFlush;
    // Fetch only beats a pending data access once it has been starved
    assign grant_fetch = (state_q == IDLE) & fetch_ok &
                         (~data_req | (starve_q == LIMIT));
    assign grant_data  = (state_q == IDLE) & data_req & ~grant_fetch;

`ifdef ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] timer_q, timer_d;

    always_comb begin
        timer_d = timer_q;
        if (grant_fetch || grant_data)
            timer_d = '0;
        else if (state_q != IDLE)
            timer_d = timer_q + TW'(1);
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) timer_q <= '0;
        else         timer_q <= timer_d;
    end

    assign timeout = (state_q != IDLE) &&
                     (timer_q == TW'(TIMEOUT_CYCLES - 1));
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYCLES == 0);
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d       = state_q;
        mem_req_d     = mem_req_q;
        mem_write_d   = mem_write_q;
        mem_addr_d    = mem_addr_q;
        mem_wdata_d   = mem_wdata_q;
        mem_be_d      = mem_be_q;
        fetch_ready_d = 1'b0;
        fetch_rdata_d = fetch_rdata_q;
        data_ready_d  = 1'b0;
        data_rdata_d  = data_rdata_q;
        fault_d       = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (grant_fetch) begin
                    state_d     = FETCH;
                    mem_req_d   = 1'b1;
                    mem_write_d = 1'b0;
                    mem_addr_d  = bus.fetchAddress;
                    mem_wdata_d = '0;
                    mem_be_d    = 4'hF;
                end else if (grant_data) begin
                    state_d     = DATA;
                    mem_req_d   = 1'b1;
                    mem_write_d = bus.dataWriteEnable;
                    mem_addr_d  = bus.dataAddress;
                    mem_wdata_d = bus.dataWriteData;
                    mem_be_d    = bus.dataWriteEnable ?
                                  bus.dataByteEnable : 4'hF;
                end
            end
            FETCH: begin
                if (bus.memAcknowledge) begin
                    state_d   = IDLE;
                    mem_req_d = 1'b0;
                    if (!bus.fetchFlush) begin
                        fetch_ready_d = 1'b1;
                        fetch_rdata_d = bus.memReadData;
                    end
                end else if (bus.fetchFlush) begin
                    state_d = FETCH_DROP;
                end else if (timeout) begin
                    state_d       = IDLE;
                    mem_req_d     = 1'b0;
                    fetch_ready_d = 1'b1;
                    fetch_rdata_d = '0;
                    fault_d       = 1'b1;
                end
            end
            DATA: begin
                if (bus.memAcknowledge) begin
                    state_d      = IDLE;
                    mem_req_d    = 1'b0;
                    data_ready_d = 1'b1;
                    if (!mem_write_q)
                        data_rdata_d = bus.memReadData;
                end else if (timeout) begin
                    state_d      = IDLE;
                    mem_req_d    = 1'b0;
                    data_ready_d = 1'b1;
                    data_rdata_d = '0;
                    fault_d      = 1'b1;
                end
            end
            FETCH_DROP: begin
                if (bus.memAcknowledge || timeout) begin
                    state_d   = IDLE;
                    mem_req_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        starve_d = starve_q;
        if (!bus.fetchRequest || grant_fetch)
            starve_d = '0;
        else if (grant_data && starve_q != LIMIT)
            starve_d = starve_q + 4'd1;
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state_q       <= IDLE;
            starve_q      <= '0;
            mem_req_q     <= 1'b0;
            mem_write_q   <= 1'b0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            mem_be_q      <= '0;
            fetch_ready_q <= 1'b0;
            fetch_rdata_q <= '0;
            data_ready_q  <= 1'b0;
            data_rdata_q  <= '0;
            fault_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            starve_q      <= starve_d;
            mem_req_q     <= mem_req_d;
            mem_write_q   <= mem_write_d;
            mem_addr_q    <= mem_addr_d;
            mem_wdata_q   <= mem_wdata_d;
            mem_be_q      <= mem_be_d;
            fetch_ready_q <= fetch_ready_d;
            fetch_rdata_q <= fetch_rdata_d;
            data_ready_q  <= data_ready_d;
            data_rdata_q  <= data_rdata_d;
            fault_q       <= fault_d;
        end
    end

    assign bus.memRequest    = mem_req_q;
    assign bus.memWrite      = mem_write_q;
    assign bus.memAddress    = mem_addr_q;
    assign bus.memWriteData  = mem_wdata_q;
    assign bus.memByteEnable = mem_be_q;
    assign bus.fetchReady    = fetch_ready_q;
    assign bus.fetchReadData = fetch_rdata_q;
    assign bus.dataReady     = data_ready_q;
    assign bus.dataReadData  = data_rdata_q;
    assign bus.accessFault   = fault_q;
endmodule

// File: tb/tb_unified_memory_arbiter.sv
// Directed bench for unified_memory_arbiter: arbitration,
// starvation, flush, reset and (with ARB_TIMEOUT_EN) timeout.
module tb_unified_memory_arbiter;
    logic clock;
    logic resetN;
    int   total = 0;
    int   bad   = 0;

    unified_memory_arbiter_if bus ();

    unified_memory_arbiter #(
        .STARVE_LIMIT   (4),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clock  (clock),
        .resetN (resetN),
        .bus    (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        resetN              = 1'b0;
        bus.fetchRequest    = 1'b0;
        bus.fetchAddress    = '0;
        bus.fetchFlush      = 1'b0;
        bus.dataReadEnable  = 1'b0;
        bus.dataWriteEnable = 1'b0;
        bus.dataAddress     = '0;
        bus.dataWriteData   = '0;
        bus.dataByteEnable  = '0;
        bus.memAcknowledge  = 1'b0;
        bus.memReadData     = '0;
        tick();
        tick();
        chk("rst_memreq", 32'(bus.memRequest), 0);
        chk("rst_be", 32'(bus.memByteEnable), 0);
        chk("rst_fault", 32'(bus.accessFault), 0);
        resetN = 1'b1;
        tick();

        // fetch only
        bus.fetchRequest = 1'b1;
        bus.fetchAddress = 32'h8000_0000;
        tick();
        chk("f1_req", 32'(bus.memRequest), 1);
        chk("f1_addr", bus.memAddress, 32'h8000_0000);
        chk("f1_be", 32'(bus.memByteEnable), 32'hF);
        chk("f1_wr", 32'(bus.memWrite), 0);
        tick();
        bus.memAcknowledge = 1'b1;
        bus.memReadData    = 32'h0000_0013;
        tick();
        bus.memAcknowledge = 1'b0;
        bus.fetchRequest   = 1'b0;
        chk("f1_rdy", 32'(bus.fetchReady), 1);
        chk("f1_data", bus.fetchReadData, 32'h0000_0013);
        tick();
        chk("f1_rdy_off", 32'(bus.fetchReady), 0);
        chk("f1_req_off", 32'(bus.memRequest), 0);

        // ack in IDLE is ignored
        bus.memAcknowledge = 1'b1;
        tick();
        bus.memAcknowledge = 1'b0;
        chk("idle_ack_f", 32'(bus.fetchReady), 0);
        chk("idle_ack_d", 32'(bus.dataReady), 0);
        chk("idle_ack_req", 32'(bus.memRequest), 0);

        // fetch and store together: store first
        bus.fetchRequest    = 1'b1;
        bus.fetchAddress    = 32'h8000_0100;
        bus.dataWriteEnable = 1'b1;
        bus.dataAddress     = 32'h8000_1000;
        bus.dataWriteData   = 32'hDEAD_BEEF;
        bus.dataByteEnable  = 4'b0011;
        tick();
        chk("st_req", 32'(bus.memRequest), 1);
        chk("st_wr", 32'(bus.memWrite), 1);
        chk("st_addr", bus.memAddress, 32'h8000_1000);
        chk("st_wdata", bus.memWriteData, 32'hDEAD_BEEF);
        chk("st_be", 32'(bus.memByteEnable), 32'h3);
        bus.memAcknowledge = 1'b1;
        tick();
        bus.memAcknowledge  = 1'b0;
        bus.dataWriteEnable = 1'b0;
        chk("st_rdy", 32'(bus.dataReady), 1);
        tick();
        chk("st_f_req", 32'(bus.memRequest), 1);
        chk("st_f_wr", 32'(bus.memWrite), 0);
        chk("st_f_addr", bus.memAddress, 32'h8000_0100);
        chk("st_f_be", 32'(bus.memByteEnable), 32'hF);
        bus.memAcknowledge = 1'b1;
        bus.memReadData    = 32'h1111_1111;
        tick();
        bus.memAcknowledge = 1'b0;
        bus.fetchRequest   = 1'b0;
        chk("st_f_rdy", 32'(bus.fetchReady), 1);
        chk("st_f_data", bus.fetchReadData, 32'h1111_1111);
        tick();

        // starvation: 4 loads, then fetch, then loads resume
        bus.fetchRequest   = 1'b1;
        bus.fetchAddress   = 32'h8000_0200;
        bus.dataReadEnable = 1'b1;
        bus.dataAddress    = 32'h8000_2000;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("sv_ld%0d_addr", i), bus.memAddress,
                32'h8000_2000);
            chk($sformatf("sv_ld%0d_wr", i), 32'(bus.memWrite), 0);
            bus.memAcknowledge = 1'b1;
            bus.memReadData    = 32'hA000_0000 + 32'(i);
            tick();
            bus.memAcknowledge = 1'b0;
            chk($sformatf("sv_ld%0d_rdy", i), 32'(bus.dataReady), 1);
            chk($sformatf("sv_ld%0d_data", i), bus.dataReadData,
                32'hA000_0000 + 32'(i));
        end
        tick();
        chk("sv_f_addr", bus.memAddress, 32'h8000_0200);
        chk("sv_f_be", 32'(bus.memByteEnable), 32'hF);
        bus.memAcknowledge = 1'b1;
        bus.memReadData    = 32'h2222_2222;
        tick();
        bus.memAcknowledge = 1'b0;
        chk("sv_f_rdy", 32'(bus.fetchReady), 1);
        chk("sv_f_data", bus.fetchReadData, 32'h2222_2222);
        tick();
        chk("sv_resume_addr", bus.memAddress, 32'h8000_2000);
        chk("sv_resume_req", 32'(bus.memRequest), 1);
        bus.memAcknowledge = 1'b1;
        bus.memReadData    = 32'hB000_0001;
        tick();
        bus.memAcknowledge = 1'b0;
        bus.dataReadEnable = 1'b0;
        bus.fetchRequest   = 1'b0;
        chk("sv_resume_rdy", 32'(bus.dataReady), 1);
        chk("sv_resume_data", bus.dataReadData, 32'hB000_0001);
        tick();

        // flush during fetch, late ack
        bus.fetchRequest = 1'b1;
        bus.fetchAddress = 32'h8000_0300;
        tick();
        chk("fl_req", 32'(bus.memRequest), 1);
        bus.fetchFlush   = 1'b1;
        bus.fetchRequest = 1'b0;
        tick();
        bus.fetchFlush = 1'b0;
        chk("fl_hold1", 32'(bus.memRequest), 1);
        tick();
        chk("fl_hold2", 32'(bus.memRequest), 1);
        chk("fl_addr", bus.memAddress, 32'h8000_0300);
        tick();
        bus.memAcknowledge = 1'b1;
        bus.memReadData    = 32'h3333_3333;
        bus.fetchRequest   = 1'b1;
        bus.fetchAddress   = 32'h8000_0040;
        chk("fl_hold3", 32'(bus.memRequest), 1);
        chk("fl_addr3", bus.memAddress, 32'h8000_0300);
        tick();
        bus.memAcknowledge = 1'b0;
        chk("fl_no_rdy", 32'(bus.fetchReady), 0);
        chk("fl_drop", 32'(bus.memRequest), 0);
        chk("fl_keep_data", bus.fetchReadData, 32'h2222_2222);
        tick();
        chk("fl_new_req", 32'(bus.memRequest), 1);
        chk("fl_new_addr", bus.memAddress, 32'h8000_0040);
        bus.memAcknowledge = 1'b1;
        bus.memReadData    = 32'h4444_4444;
        tick();
        bus.memAcknowledge = 1'b0;
        bus.fetchRequest   = 1'b0;
        chk("fl_new_rdy", 32'(bus.fetchReady), 1);
        chk("fl_new_data", bus.fetchReadData, 32'h4444_4444);
        tick();

        // flush and ack in the same cycle
        bus.fetchRequest = 1'b1;
        bus.fetchAddress = 32'h8000_0400;
        tick();
        bus.fetchFlush     = 1'b1;
        bus.fetchRequest   = 1'b0;
        bus.memAcknowledge = 1'b1;
        bus.memReadData    = 32'h5555_5555;
        tick();
        bus.fetchFlush     = 1'b0;
        bus.memAcknowledge = 1'b0;
        chk("fa_no_rdy", 32'(bus.fetchReady), 0);
        chk("fa_req", 32'(bus.memRequest), 0);
        tick();
        chk("fa_no_rdy2", 32'(bus.fetchReady), 0);

        // read and write both high is a write
        bus.dataReadEnable  = 1'b1;
        bus.dataWriteEnable = 1'b1;
        bus.dataAddress     = 32'h8000_3000;
        bus.dataWriteData   = 32'h0BAD_F00D;
        bus.dataByteEnable  = 4'b1100;
        tick();
        chk("rw_wr", 32'(bus.memWrite), 1);
        chk("rw_be", 32'(bus.memByteEnable), 32'hC);
        bus.memAcknowledge = 1'b1;
        bus.memReadData    = 32'h6666_6666;
        tick();
        bus.memAcknowledge  = 1'b0;
        bus.dataReadEnable  = 1'b0;
        bus.dataWriteEnable = 1'b0;
        chk("rw_rdy", 32'(bus.dataReady), 1);
        chk("rw_no_load", bus.dataReadData, 32'hB000_0001);
        tick();

`ifdef ARB_TIMEOUT_EN
        // load never acknowledged
        bus.dataReadEnable = 1'b1;
        bus.dataAddress    = 32'h8000_4000;
        tick();
        chk("to_req", 32'(bus.memRequest), 1);
        for (int i = 0; i < 7; i++) tick();
        chk("to_req_last", 32'(bus.memRequest), 1);
        chk("to_no_rdy", 32'(bus.dataReady), 0);
        tick();
        bus.dataReadEnable = 1'b0;
        chk("to_rdy", 32'(bus.dataReady), 1);
        chk("to_fault", 32'(bus.accessFault), 1);
        chk("to_data", bus.dataReadData, 32'h0);
        chk("to_req_off", 32'(bus.memRequest), 0);
        tick();
        chk("to_fault_off", 32'(bus.accessFault), 0);
`endif

        // async reset while a data access is in flight
        bus.dataReadEnable = 1'b1;
        bus.dataAddress    = 32'h8000_5000;
        tick();
        chk("rs_req", 32'(bus.memRequest), 1);
        #2;
        resetN = 1'b0;
        #1;
        chk("rs_memreq", 32'(bus.memRequest), 0);
        chk("rs_memwr", 32'(bus.memWrite), 0);
        chk("rs_addr", bus.memAddress, 0);
        chk("rs_wdata", bus.memWriteData, 0);
        chk("rs_be", 32'(bus.memByteEnable), 0);
        chk("rs_frdy", 32'(bus.fetchReady), 0);
        chk("rs_fdata", bus.fetchReadData, 0);
        chk("rs_drdy", 32'(bus.dataReady), 0);
        chk("rs_ddata", bus.dataReadData, 0);
        chk("rs_fault", 32'(bus.accessFault), 0);
        bus.dataReadEnable = 1'b0;
        tick();
        resetN = 1'b1;
        tick();
        chk("rs_idle_req", 32'(bus.memRequest), 0);
        chk("rs_state", 32'(dut.state_q), 0);
        chk("rs_starve", 32'(dut.starve_q), 0);
        bus.fetchRequest = 1'b1;
        bus.fetchAddress = 32'h8000_0500;
        tick();
        chk("rs_grant", 32'(bus.memRequest), 1);
        chk("rs_grant_addr", bus.memAddress, 32'h8000_0500);
        bus.memAcknowledge = 1'b1;
        bus.memReadData    = 32'h7777_7777;
        tick();
        bus.memAcknowledge = 1'b0;
        bus.fetchRequest   = 1'b0;
        chk("rs_f_rdy", 32'(bus.fetchReady), 1);
        chk("rs_f_data", bus.fetchReadData, 32'h7777_7777);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
